// File: rtl/arb_pkg.sv
// Shared definitions for the two-channel arbiter requester and its arbiter.
package arb_pkg;

    localparam int unsigned NUM_REQ    = 2;
    localparam int unsigned ARB_DATA_W = 8;
    localparam int unsigned ARB_DEPTH  = 4;

    typedef logic [NUM_REQ-1:0] grant_t;

    // A grant vector is legal when it selects at most one channel.
    function automatic logic grant_legal(input grant_t g);
        return !(&g);
    endfunction

endpackage

// File: rtl/arb_requester_if.sv
// Push, arbitration and delivery signals of the arbiter requester.
interface arb_requester_if
    import arb_pkg::*;
#(
    parameter int unsigned DATA_W = ARB_DATA_W
);

    logic [NUM_REQ-1:0] in_valid;
    logic [DATA_W-1:0]  in_data0;
    logic [DATA_W-1:0]  in_data1;
    logic [NUM_REQ-1:0] in_ready;
    logic [NUM_REQ-1:0] request;
    grant_t             grant;
    logic               out_valid;
    logic [DATA_W-1:0]  out_data;
    logic               out_id;
    logic               grant_err;

    modport master (
        output in_valid, in_data0, in_data1, grant,
        input  in_ready, request, out_valid, out_data, out_id, grant_err
    );

    modport slave (
        input  in_valid, in_data0, in_data1, grant,
        output in_ready, request, out_valid, out_data, out_id, grant_err
    );

endinterface

// File: rtl/req_fifo.sv
// Per-channel queue: wrap-around pointers, occupancy count, head exposed combinationally.
module req_fifo
    import arb_pkg::*;
#(
    parameter int unsigned DATA_W = ARB_DATA_W,
    parameter int unsigned DEPTH  = ARB_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [DATA_W-1:0]      push_data,
    input  logic                   pop,
    output logic [DATA_W-1:0]      head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push_ok;
    logic              w_pop_ok;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head      = r_mem[r_rd_ptr];
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;

    // Storage carries no reset; the count alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/arb_requester.sv
// Two queued channels requesting a registered two-way arbiter; granted heads are
// delivered one cycle after the pop, and protocol violations latch a sticky flag.
module arb_requester
    import arb_pkg::*;
#(
    parameter int unsigned DATA_W = ARB_DATA_W,
    parameter int unsigned DEPTH  = ARB_DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    arb_requester_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    grant_t             w_grant;
    logic               w_legal;
    logic               w_viol;
    logic [NUM_REQ-1:0] w_push;
    logic [NUM_REQ-1:0] w_pop;
    logic [NUM_REQ-1:0] w_full;
    logic [NUM_REQ-1:0] w_empty;
    logic [NUM_REQ-1:0] w_req;
    logic [NUM_REQ-1:0] w_ready;
    logic [CNT_W-1:0]   w_count [NUM_REQ];
    logic [DATA_W-1:0]  w_head  [NUM_REQ];

    logic               r_out_valid;
    logic [DATA_W-1:0]  r_out_data;
    logic               r_out_id;
    logic               r_grant_err;

    req_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo0 (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push[0]),
        .push_data (bus.in_data0),
        .pop       (w_pop[0]),
        .head      (w_head[0]),
        .full      (w_full[0]),
        .empty     (w_empty[0]),
        .count     (w_count[0])
    );

    req_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo1 (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push[1]),
        .push_data (bus.in_data1),
        .pop       (w_pop[1]),
        .head      (w_head[1]),
        .full      (w_full[1]),
        .empty     (w_empty[1]),
        .count     (w_count[1])
    );

    // Request drops in the cycle that pops the last entry, so a registered
    // arbiter never grants a channel that has just gone empty.
    always_comb begin
        w_grant = bus.grant;
        w_legal = grant_legal(w_grant);
        w_push  = '0;
        w_pop   = '0;
        w_req   = '0;
        w_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_ready[i] = !reset && !w_full[i];
            w_push[i]  = !reset && bus.in_valid[i] && !w_full[i];
            w_pop[i]   = !reset && w_grant[i] && w_legal && !w_empty[i];
            w_req[i]   = !reset && !w_empty[i] &&
                         !((w_count[i] == CNT_W'(1)) && w_pop[i]);
        end
        w_viol = !reset && (!w_legal || (|(w_grant & w_empty)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_id    <= 1'b0;
            r_grant_err <= 1'b0;
        end else begin
            r_out_valid <= |w_pop;
            if (|w_pop) begin
                r_out_data <= w_pop[1] ? w_head[1] : w_head[0];
                r_out_id   <= w_pop[1];
            end
            r_grant_err <= r_grant_err | w_viol;
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.request   = w_req;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_id    = r_out_id;
    assign bus.grant_err = r_grant_err;

endmodule

// File: tb/tb_arb_requester.sv
// Directed and randomized bench for arb_requester against a queue-based reference model.
module tb_arb_requester;
    import arb_pkg::*;

    localparam int unsigned DW = 8;
    localparam int unsigned DP = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    arb_requester_if #(.DATA_W(DW)) bus ();

    arb_requester #(.DATA_W(DW), .DEPTH(DP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: one queue per channel plus expected registered outputs.
    logic [DW-1:0] q0 [$];
    logic [DW-1:0] q1 [$];
    logic          m_known = 1'b0;
    logic          m_ov    = 1'b0;
    logic [DW-1:0] m_od    = '0;
    logic          m_id    = 1'b0;
    logic          m_err   = 1'b0;
    logic [1:0]    m_req_last = 2'b00;
    int            rr_last = 1;
    int            dut_words = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: drive, compare at negedge, advance model, pass the edge.
    task automatic step(input logic rst, input logic [1:0] iv,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                        input logic [1:0] g);
        int         sz [2];
        logic [1:0] e_ready;
        logic [1:0] e_req;
        logic [1:0] pop;
        reset        = rst;
        bus.in_valid = iv;
        bus.in_data0 = d0;
        bus.in_data1 = d1;
        bus.grant    = g;
        sz[0] = q0.size();
        sz[1] = q1.size();
        for (int i = 0; i < 2; i++) begin
            pop[i]     = !rst && g[i] && (g != 2'b11) && (sz[i] != 0);
            e_ready[i] = !rst && (sz[i] != DP);
            e_req[i]   = !rst && (sz[i] != 0) && !((sz[i] == 1) && pop[i]);
        end
        @(negedge clk);
        check("in_ready", 32'(bus.in_ready), 32'(e_ready));
        check("request", 32'(bus.request), 32'(e_req));
        if (bus.out_valid === 1'b1) dut_words++;
        if (m_known) begin
            check("out_valid", 32'(bus.out_valid), 32'(m_ov));
            check("grant_err", 32'(bus.grant_err), 32'(m_err));
            if (m_ov) begin
                check("out_data", 32'(bus.out_data), 32'(m_od));
                check("out_id", 32'(bus.out_id), 32'(m_id));
            end
        end
        if (rst) begin
            q0.delete();
            q1.delete();
            m_ov    = 1'b0;
            m_od    = '0;
            m_id    = 1'b0;
            m_err   = 1'b0;
            m_known = 1'b1;
        end else begin
            if ((g == 2'b11) || (g[0] && sz[0] == 0) || (g[1] && sz[1] == 0)) m_err = 1'b1;
            m_ov = |pop;
            if (pop[0]) begin
                m_od = q0.pop_front();
                m_id = 1'b0;
            end else if (pop[1]) begin
                m_od = q1.pop_front();
                m_id = 1'b1;
            end
            if (iv[0] && e_ready[0]) q0.push_back(d0);
            if (iv[1] && e_ready[1]) q1.push_back(d1);
        end
        m_req_last = e_req;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int         words_before;
        logic [1:0] g;
        reset        = 1'b1;
        bus.in_valid = 2'b11;
        bus.in_data0 = '0;
        bus.in_data1 = '0;
        bus.grant    = 2'b00;

        // Reset held with pushes and grants applied: everything ignored.
        for (int k = 0; k < 10; k++) step(1'b1, 2'b11, 8'h11, 8'h22, 2'b11);
        check("rst_out_data", 32'(bus.out_data), 32'h0);
        check("rst_out_id", 32'(bus.out_id), 32'h0);
        step(1'b0, 2'b00, 8'h00, 8'h00, 2'b00);
        step(1'b0, 2'b00, 8'h00, 8'h00, 2'b00);

        // Three words on channel 0 drained by consecutive grants.
        step(1'b0, 2'b01, 8'hA1, 8'h00, 2'b00);
        step(1'b0, 2'b01, 8'hA2, 8'h00, 2'b00);
        step(1'b0, 2'b01, 8'hA3, 8'h00, 2'b00);
        for (int k = 0; k < 3; k++) step(1'b0, 2'b00, 8'h00, 8'h00, 2'b01);
        step(1'b0, 2'b00, 8'h00, 8'h00, 2'b00);
        check("a_drained_err", 32'(bus.grant_err), 32'h0);

        // Both channels full, alternating grants interleave the output.
        for (int k = 0; k < 4; k++) step(1'b0, 2'b11, 8'(8'hC0 + k), 8'(8'hD0 + k), 2'b00);
        words_before = dut_words;
        for (int k = 0; k < 8; k++) step(1'b0, 2'b00, 8'h00, 8'h00, (k % 2 == 0) ? 2'b01 : 2'b10);
        step(1'b0, 2'b00, 8'h00, 8'h00, 2'b00);
        check("interleave_words", 32'(dut_words - words_before), 32'd8);

        // Channel 1 filled; pop plus push at full refuses the push.
        for (int k = 0; k < 4; k++) step(1'b0, 2'b10, 8'h00, 8'(8'hB1 + k), 2'b00);
        step(1'b0, 2'b10, 8'h00, 8'hB5, 2'b10);
        for (int k = 0; k < 3; k++) step(1'b0, 2'b00, 8'h00, 8'h00, 2'b10);
        step(1'b0, 2'b00, 8'h00, 8'h00, 2'b00);

        // Illegal grant 11 with both loaded: no pop, sticky error until reset.
        step(1'b0, 2'b11, 8'h31, 8'h41, 2'b00);
        step(1'b0, 2'b00, 8'h00, 8'h00, 2'b11);
        for (int k = 0; k < 3; k++) step(1'b0, 2'b00, 8'h00, 8'h00, 2'b00);
        step(1'b1, 2'b00, 8'h00, 8'h00, 2'b00);
        step(1'b1, 2'b00, 8'h00, 8'h00, 2'b00);
        // Grant of empty channel 0 while channel 1 holds data.
        step(1'b0, 2'b10, 8'h00, 8'h51, 2'b00);
        step(1'b0, 2'b00, 8'h00, 8'h00, 2'b01);
        step(1'b0, 2'b00, 8'h00, 8'h00, 2'b00);
        step(1'b0, 2'b00, 8'h00, 8'h00, 2'b00);

        // Reset mid-burst discards queued words.
        step(1'b1, 2'b00, 8'h00, 8'h00, 2'b00);
        for (int k = 0; k < 3; k++) step(1'b0, 2'b01, 8'(8'h61 + k), 8'h00, 2'b00);
        step(1'b0, 2'b00, 8'h00, 8'h00, 2'b01);
        step(1'b1, 2'b00, 8'h00, 8'h00, 2'b01);
        step(1'b0, 2'b00, 8'h00, 8'h00, 2'b01);
        step(1'b0, 2'b00, 8'h00, 8'h00, 2'b10);
        step(1'b0, 2'b00, 8'h00, 8'h00, 2'b00);
        step(1'b1, 2'b00, 8'h00, 8'h00, 2'b00);

        // Random traffic with a round-robin registered arbiter and rare resets.
        for (int k = 0; k < 400; k++) begin
            if (m_req_last == 2'b11) g = (rr_last == 0) ? 2'b10 : 2'b01;
            else                     g = m_req_last;
            if (g == 2'b01) rr_last = 0;
            if (g == 2'b10) rr_last = 1;
            step(($urandom_range(0, 63) == 0), 2'($urandom), 8'($urandom), 8'($urandom), g);
        end
        step(1'b0, 2'b00, 8'h00, 8'h00, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/arb_requester.md
ARB_REQUESTER -- requirements
Module: arb_requester

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload width per queued word.
REQ-002 SHALL have parameter DEPTH, default 4, entries per channel queue (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  2  per-channel push strobe.
REQ-006 SHALL have port in_data0 / in_data1  input  DATA_W each  push payload, channel 0 / channel 1.
REQ-007 SHALL have port in_ready  output  2  per-channel queue-not-full.
REQ-008 SHALL have port request  output  2  request vector to the two-way arbiter.
REQ-009 SHALL have port grant  input  2  grant vector from the arbiter, registered and valid one cycle after request.
REQ-010 SHALL have port out_valid  output  1  one word delivered this cycle.
REQ-011 SHALL have port out_data  output  DATA_W  delivered word.
REQ-012 SHALL have port out_id  output  1  channel of delivered word.
REQ-013 SHALL have port grant_err  output  1  sticky arbiter protocol violation flag.

Function
REQ-014 SHALL keep one FIFO per channel with wrap-around read/write pointers and a count in 0..DEPTH.
REQ-015 SHALL drive in_ready[i] = (count_i != DEPTH), ignoring any same-cycle pop; a push with in_valid[i] && in_ready[i] writes the word.
REQ-016 SHALL pop channel i when grant[i] is high, grant != 2'b11, and count_i != 0.
REQ-017 SHALL register the popped head so out_valid=1, out_data=head, out_id=i in the cycle after the pop; out_valid=0 otherwise; the consumer applies no backpressure.
REQ-018 SHALL drive request[i] combinationally as count_i != 0, except 0 when count_i==1 and a pop of channel i occurs this cycle, so a well-behaved arbiter never grants an empty channel.
REQ-019 SHALL leave count unchanged on simultaneous push and pop of a non-full channel; both take effect.
REQ-020 SHALL set grant_err on grant==2'b11 (no pop occurs) or on grant[i] with count_i==0 (no pop, out_valid stays 0); grant_err clears only on reset.
REQ-021 SHALL preserve per-channel FIFO order; channel interleaving follows the grant order.

Reset
REQ-022 SHALL, while reset is high, force counts and pointers to 0, in_ready=2'b00, request=2'b00, out_valid=0, out_data=0, out_id=0, grant_err=0, and ignore in_valid and grant.
REQ-023 SHALL discard queued entries on reset asserted mid-operation; request=2'b00 in the cycle after the reset edge.

Structure
REQ-024 SHALL take NUM_REQ=2, DATA_W and DEPTH defaults from shared package arb_pkg, which also holds the grant-vector typedef used by the arbiter.
REQ-025 SHALL implement each queue as sub-module req_fifo (push/pop/full/empty/count), instantiated twice.

Verification
REQ-026 Reset held 10 cycles with in_valid=2'b11 -> in_ready=00, request=00, out_valid=0; after release request=00, grant_err=0.
REQ-027 Push 8'hA1,8'hA2,8'hA3 on channel 0, arbiter model grants 01 each cycle -> out_data A1,A2,A3 on consecutive cycles, out_id=0, request[0] low in the final pop cycle, grant_err=0.
REQ-028 Load 4 words per channel, arbiter alternating with request=11 -> output out_id 0,1,0,1,...; all 8 words delivered, per-channel order kept.
REQ-029 Push 4 words on channel 1 without grants -> in_ready[1]=0; push with simultaneous pop at full is refused, count becomes 3.
REQ-030 Drive grant=2'b11 with both queues loaded -> no pop, out_valid=0, grant_err=1 until reset; also grant=01 with channel 0 empty -> grant_err=1, out_valid=0.
REQ-031 Reset asserted mid-burst with 3 words queued -> request=00 next cycle, out_valid=0, subsequent grants produce no output.
